simd_inst_sequencer: RTL
========================

# simd_inst_sequencer

Issues a warp's ALU program into the SIMD ALU one instruction per handshake, driving the ALU `op` rdy/ack port. It accepts a warp descriptor (warp id, program window, repeat count) and walks the program window `i_n_rep` times. For each instruction it emits registered decoded fields, including the per-warp register write address. It pulses completion when the warp's last instruction is acked. It sits between the warp scheduler and the ALU in the SIMD pipeline.

## Interface
Parameters:
- `N_INST`, 16: instruction slots in `i_insts`; `PC_BW = $clog2(N_INST)`.
- `MAX_WARP`, 8: warps; `WID_BW = $clog2(MAX_WARP)`.
- `REG_ADDR`, 32: register words per warp; `REG_ABW = $clog2(REG_ADDR)`.
- `REP_BW`, 8: repeat-count width.
- Derived: `SRAM_ABW = $clog2(MAX_WARP*REG_ADDR)`, `INST_BW = 24+REG_ABW`.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `warp_rdy` in 1 / `warp_ack` out 1: warp descriptor handshake.
- `i_warp_id` in WID_BW: warp id.
- `i_pc_beg` in PC_BW: first instruction slot.
- `i_n_inst` in PC_BW+1: instructions per pass.
- `i_n_rep` in REP_BW: number of passes.
- `i_insts` in [N_INST][INST_BW]: instruction words; static while busy.
- `op_rdy` out 1 / `op_ack` in 1: ALU issue handshake.
- `o_opcode` out 3, `o_shamt` out 5, `o_a`/`o_b`/`o_c` out 3 each, `o_to_reg` out 1, `o_to_dram` out 2, `o_to_temp` out 1: decoded instruction fields.
- `o_reg_waddr` out SRAM_ABW: `warp_id*REG_ADDR + reg_off`.
- `o_last` out 1: the current op is the warp's final instruction.
- `done_dval` out 1: one-cycle completion pulse.
- `o_done_warp_id` out WID_BW: id of the completed warp.

## Operation
- Instruction word layout, LSB first: `reg_off[REG_ABW]`, `to_temp`, `to_dram[2]`, `to_reg`, `c[3]`, `b[3]`, `a[3]`, `shamt[5]`, `opcode[3]`, 3 reserved bits (ignored).
- FSM states are IDLE and ISSUE.
- `warp_ack = warp_rdy && state==IDLE`.
- On `warp_ack`:
  - latch the descriptor;
  - set `pc=i_pc_beg`, `cnt=0`, `rep=0`;
  - register the fields of `i_insts[i_pc_beg]`.
- Zero-work warp (`i_n_inst==0` or `i_n_rep==0`): stay in IDLE; `done_dval` pulses next cycle with no op issued.
- Otherwise go to ISSUE.
- ISSUE: `op_rdy=1`. All output fields are registered and held stable while `op_rdy && !op_ack`.
- On `op_ack`, advance:
  - if `cnt+1 < n_inst`: `cnt++`, `pc++`;
  - else if `rep+1 < n_rep`: `cnt=0`, `pc=pc_beg`, `rep++`;
  - else: go to IDLE and pulse `done_dval` next cycle with `o_done_warp_id`.
- The next instruction's fields are registered in the same cycle as `op_ack`, so sustained `op_ack` gives one instruction per cycle.
- `pc` wraps modulo N_INST, since `pc_beg+n_inst` may exceed N_INST.
- `o_last = (cnt==n_inst-1) && (rep==n_rep-1)`, registered with the fields.
- `o_reg_waddr` is computed at register load. The multiply is by a power of two, so it is a concatenation `{warp_id, reg_off}`.

## Timing
- Reset: state IDLE; `op_rdy=0`, `warp_ack=0`, `done_dval=0`; all field outputs, `o_last`, `o_reg_waddr` and `o_done_warp_id` are 0.
- Latency: `op_rdy` rises the cycle after `warp_ack`.
- `done_dval` rises the cycle after the final `op_ack`. State is already IDLE in that cycle, so a new `warp_ack` may occur in the same cycle as `done_dval` (back-to-back warps, one bubble).
- `op_ack` without `op_rdy` is illegal: assert in simulation, ignored in RTL.
- `warp_rdy` while in ISSUE is held off (`warp_ack=0`); the descriptor must stay stable until acked.
- Reset mid-warp: on the next cycle `op_rdy=0` and no `done_dval` is produced; the warp is dropped.

## Structure
- Shared package `TauCfg`: `MAX_WARP`, `WARP_REG_ADDR_SPACE` (REG_ADDR), and a new `SIMD_N_INST`.
- Shared package also holds an `AluInst` packed-struct typedef with the field layout above, reused by the ALU-side decode.
- Local to the block: the FSM enum and the pc/cnt/rep counters.
- One sub-module, `SimdInstDecode`: purely combinational slice of `i_insts[pc]` into `AluInst` plus the `o_reg_waddr` concatenation. It is instantiated once, on the next-pc mux output.

## Test plan
- Single warp: id 3, pc_beg 2, n_inst 3, n_rep 1, `op_ack` held high -> ops from slots 2, 3, 4 on consecutive cycles; `o_reg_waddr` upper bits = 3; `o_last` only on slot 4; `done_dval` with id 3 one cycle later.
- Backpressure: `op_ack` low for 4 cycles mid-program -> all fields stable throughout, no slot skipped or duplicated.
- Repeat and wrap: pc_beg 14, n_inst 4, n_rep 2 -> slot order 14, 15, 0, 1, 14, 15, 0, 1; 8 acks; one `done_dval`.
- Zero work: n_inst 0 -> `op_rdy` never rises; `done_dval` pulses the cycle after `warp_ack`. Repeat with n_rep 0 -> same result.
- Back-to-back: second warp's `warp_rdy` held during the first warp -> `warp_ack` asserts in the same cycle as the first warp's `done_dval`; the second warp's first op follows one cycle later.
- Reset mid-ISSUE after 2 of 5 acks -> outputs are 0 next cycle, no `done_dval`, and a new warp is then accepted normally.

Source files
------------

// File: rtl/simd_inst_sequencer_pkg.sv
// Shared SIMD configuration package.
// Holds the machine-wide warp/register/program sizes and the packed ALU
// instruction layout. The sequencer and the ALU-side decode both use it.
// No ports (package).
package TauCfg;

  localparam int MAX_WARP            = 8;
  localparam int WARP_REG_ADDR_SPACE = 32;
  localparam int SIMD_N_INST         = 16;
  localparam int REG_ABW             = $clog2(WARP_REG_ADDR_SPACE);
  localparam int ALU_INST_BW         = 24 + REG_ABW;

  // Field order is MSB first, so reg_off ends up in the LSBs of the word.
  typedef struct packed {
    logic [2:0]         rsvd;
    logic [2:0]         opcode;
    logic [4:0]         shamt;
    logic [2:0]         a;
    logic [2:0]         b;
    logic [2:0]         c;
    logic               to_reg;
    logic [1:0]         to_dram;
    logic               to_temp;
    logic [REG_ABW-1:0] reg_off;
  } AluInst;

endpackage

// File: rtl/simd_inst_sequencer_decode.sv
// SimdInstDecode: combinational slice of one instruction word into AluInst
// fields plus the per-warp register write address.
// Ports:
//   inst_i      - raw instruction word
//   warp_id_i   - warp owning the instruction
//   fields_o    - decoded AluInst
//   reg_waddr_o - {warp_id, reg_off}; REG_ADDR is a power of two so the
//                 warp_id*REG_ADDR + reg_off product reduces to a concat
module SimdInstDecode
  import TauCfg::*;
#(
  parameter int WID_BW   = 3,
  parameter int SRAM_ABW = WID_BW + REG_ABW
) (
  input  logic [ALU_INST_BW-1:0] inst_i,
  input  logic [WID_BW-1:0]      warp_id_i,
  output AluInst                 fields_o,
  output logic [SRAM_ABW-1:0]    reg_waddr_o
);

  assign fields_o    = AluInst'(inst_i);
  assign reg_waddr_o = {warp_id_i, fields_o.reg_off};

endmodule

// File: rtl/simd_inst_sequencer.sv
// simd_inst_sequencer: walks a warp's program window n_rep times and issues
// one registered instruction per op_rdy/op_ack handshake into the SIMD ALU.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   warp_rdy / warp_ack     - warp descriptor handshake (ack only in IDLE)
//   i_warp_id, i_pc_beg,
//   i_n_inst, i_n_rep       - warp descriptor
//   i_insts                 - instruction slots, static while busy
//   op_rdy / op_ack         - ALU issue handshake
//   o_opcode .. o_to_temp   - registered decoded fields
//   o_reg_waddr             - registered {warp_id, reg_off}
//   o_last                  - current op is the warp's final instruction
//   done_dval, o_done_warp_id - one-cycle completion pulse and warp id
module simd_inst_sequencer #(
  parameter int N_INST   = TauCfg::SIMD_N_INST,
  parameter int MAX_WARP = TauCfg::MAX_WARP,
  parameter int REG_ADDR = TauCfg::WARP_REG_ADDR_SPACE,
  parameter int REP_BW   = 8,
  localparam int PC_BW    = $clog2(N_INST),
  localparam int WID_BW   = $clog2(MAX_WARP),
  localparam int SRAM_ABW = $clog2(MAX_WARP * REG_ADDR),
  localparam int INST_BW  = 24 + $clog2(REG_ADDR)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             warp_rdy,
  output logic                             warp_ack,
  input  logic [WID_BW-1:0]                i_warp_id,
  input  logic [PC_BW-1:0]                 i_pc_beg,
  input  logic [PC_BW:0]                   i_n_inst,
  input  logic [REP_BW-1:0]                i_n_rep,
  input  logic [N_INST-1:0][INST_BW-1:0]   i_insts,
  output logic                             op_rdy,
  input  logic                             op_ack,
  output logic [2:0]                       o_opcode,
  output logic [4:0]                       o_shamt,
  output logic [2:0]                       o_a,
  output logic [2:0]                       o_b,
  output logic [2:0]                       o_c,
  output logic                             o_to_reg,
  output logic [1:0]                       o_to_dram,
  output logic                             o_to_temp,
  output logic [SRAM_ABW-1:0]              o_reg_waddr,
  output logic                             o_last,
  output logic                             done_dval,
  output logic [WID_BW-1:0]                o_done_warp_id
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  localparam logic [PC_BW-1:0] PC_ONE  = PC_BW'(1);
  localparam logic [PC_BW:0]   CNT_ONE = (PC_BW + 1)'(1);
  localparam logic [REP_BW:0]  REP_ONE = (REP_BW + 1)'(1);

  state_e               state_q, state_d;
  logic [PC_BW-1:0]     pc_q, pc_d, pc_beg_q, pc_beg_d;
  logic [PC_BW:0]       cnt_q, cnt_d, n_inst_q, n_inst_d, cnt_inc_s;
  logic [REP_BW-1:0]    rep_q, rep_d, n_rep_q, n_rep_d;
  logic [REP_BW:0]      rep_inc_s;
  logic [WID_BW-1:0]    wid_q, wid_d, done_id_q, done_id_d, sel_wid_s;
  logic                 done_q, done_d, last_q, last_d, load_s, warp_ack_s;
  logic [PC_BW-1:0]     sel_pc_s;
  TauCfg::AluInst       fld_q, dec_s;
  logic [SRAM_ABW-1:0]  waddr_q, dec_waddr_s;
  logic                 rsvd_unused_s;

  // True when (cnt, rep) addresses the final instruction of the final pass.
  function automatic logic is_last(input logic [PC_BW:0] cnt, input logic [REP_BW:0] rep1,
                                   input logic [PC_BW:0] n_inst, input logic [REP_BW-1:0] n_rep);
    return ((cnt + CNT_ONE) == n_inst) && (rep1 == {1'b0, n_rep});
  endfunction

  assign cnt_inc_s = cnt_q + CNT_ONE;
  assign rep_inc_s = {1'b0, rep_q} + REP_ONE;

  // Decode sits on the next-pc mux so fields register in the ack cycle.
  SimdInstDecode #(.WID_BW(WID_BW), .SRAM_ABW(SRAM_ABW)) u_decode (
    .inst_i      (i_insts[sel_pc_s]),
    .warp_id_i   (sel_wid_s),
    .fields_o    (dec_s),
    .reg_waddr_o (dec_waddr_s)
  );

  // Next-state, counter advance and field-load control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_beg_d   = pc_beg_q;
    cnt_d      = cnt_q;
    n_inst_d   = n_inst_q;
    rep_d      = rep_q;
    n_rep_d    = n_rep_q;
    wid_d      = wid_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    last_d     = last_q;
    load_s     = 1'b0;
    sel_pc_s   = pc_q;
    sel_wid_s  = wid_q;
    warp_ack_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (warp_rdy) begin
          warp_ack_s = 1'b1;
          pc_beg_d   = i_pc_beg;
          n_inst_d   = i_n_inst;
          n_rep_d    = i_n_rep;
          wid_d      = i_warp_id;
          pc_d       = i_pc_beg;
          cnt_d      = '0;
          rep_d      = '0;
          sel_pc_s   = i_pc_beg;
          sel_wid_s  = i_warp_id;
          load_s     = 1'b1;
          last_d     = is_last('0, REP_ONE, i_n_inst, i_n_rep);
          if ((i_n_inst == '0) || (i_n_rep == '0)) begin
            done_d    = 1'b1;
            done_id_d = i_warp_id;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (op_ack) begin
          if (cnt_inc_s < n_inst_q) begin
            cnt_d    = cnt_inc_s;
            pc_d     = pc_q + PC_ONE;   // wraps modulo N_INST
            sel_pc_s = pc_q + PC_ONE;
            load_s   = 1'b1;
            last_d   = is_last(cnt_inc_s, rep_inc_s, n_inst_q, n_rep_q);
          end else if (rep_inc_s < {1'b0, n_rep_q}) begin
            cnt_d    = '0;
            pc_d     = pc_beg_q;
            rep_d    = rep_inc_s[REP_BW-1:0];
            sel_pc_s = pc_beg_q;
            load_s   = 1'b1;
            last_d   = is_last('0, rep_inc_s + REP_ONE, n_inst_q, n_rep_q);
          end else begin
            state_d   = IDLE;
            done_d    = 1'b1;
            done_id_d = wid_q;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, descriptor, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      pc_beg_q  <= '0;
      cnt_q     <= '0;
      n_inst_q  <= '0;
      rep_q     <= '0;
      n_rep_q   <= '0;
      wid_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      last_q    <= 1'b0;
      fld_q     <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_beg_q  <= pc_beg_d;
      cnt_q     <= cnt_d;
      n_inst_q  <= n_inst_d;
      rep_q     <= rep_d;
      n_rep_q   <= n_rep_d;
      wid_q     <= wid_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      last_q    <= last_d;
      if (load_s) begin
        fld_q   <= dec_s;
        waddr_q <= dec_waddr_s;
      end
    end
  end

  assign rsvd_unused_s  = ^fld_q.rsvd;
  assign warp_ack       = warp_ack_s;
  assign op_rdy         = (state_q == ISSUE);
  assign o_opcode       = fld_q.opcode;
  assign o_shamt        = fld_q.shamt;
  assign o_a            = fld_q.a;
  assign o_b            = fld_q.b;
  assign o_c            = fld_q.c;
  assign o_to_reg       = fld_q.to_reg;
  assign o_to_dram      = fld_q.to_dram;
  assign o_to_temp      = fld_q.to_temp;
  assign o_reg_waddr    = waddr_q;
  assign o_last         = last_q;
  assign done_dval      = done_q;
  assign o_done_warp_id = done_id_q;

  SimdInstSeqChk u_chk (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .op_rdy_i (op_rdy),
    .op_ack_i (op_ack)
  );

endmodule

// SimdInstSeqChk: protocol checker; an ack with no pending op is illegal
// and is otherwise ignored by the sequencer.
// Ports: clk_i, rst_i, op_rdy_i, op_ack_i.
module SimdInstSeqChk (
  input logic clk_i,
  input logic rst_i,
  input logic op_rdy_i,
  input logic op_ack_i
);

  // Flag op_ack raised while no op is offered.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(op_ack_i && !op_rdy_i)) else $error("op_ack asserted without op_rdy");
    end
  end

endmodule
